// File: rtl/synth_pkg.sv
// Shared formats and elaboration helpers for the synthesiser datapath.
package synth_pkg;

    localparam int VOICE_WI = 2;
    localparam int VOICE_WF = 16;
    localparam int MIX_WI   = 6;
    localparam int MIX_WF   = 18;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Bit offset of adder-tree level k inside a bus holding levels 0..levels back to back.
    function automatic int tree_offset(input int levels, input int win, input int k);
        int off;
        off = 0;
        for (int j = 0; j < k; j++) begin
            off += (1 << (levels - j)) * (win + j);
        end
        return off;
    endfunction

endpackage

// File: rtl/mix_add_stage.sv
// One registered level of the mixer adder tree: each operand pair is
// sign-extended by one bit, added, and registered, so the level cannot overflow.
module mix_add_stage #(
    parameter int IN_W  = 18,
    parameter int PAIRS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2*PAIRS*IN_W-1:0]   i_operands,
    output logic [PAIRS*(IN_W+1)-1:0] o_sums
);

    logic [PAIRS*(IN_W+1)-1:0] w_sums;
    logic [PAIRS*(IN_W+1)-1:0] r_sums;

    for (genvar p = 0; p < PAIRS; p++) begin : g_pair
        logic [IN_W-1:0] w_a;
        logic [IN_W-1:0] w_b;
        assign w_a = i_operands[(2*p)*IN_W +: IN_W];
        assign w_b = i_operands[(2*p+1)*IN_W +: IN_W];
        assign w_sums[p*(IN_W+1) +: IN_W+1] = {w_a[IN_W-1], w_a} + {w_b[IN_W-1], w_b};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sums <= '0;
        end else begin
            r_sums <= w_sums;
        end
    end

    assign o_sums = r_sums;

endmodule

// File: rtl/voice_mix_pipe.sv
// Pipelined voice mixer: masked voices go through a registered binary adder tree,
// then a power-of-two attenuation, fraction alignment and saturation to the mix format.
module voice_mix_pipe
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int WI_IN      = VOICE_WI,
    parameter int WF_IN      = VOICE_WF,
    parameter int WI_OUT     = MIX_WI,
    parameter int WF_OUT     = MIX_WF,
    parameter int SHIFT_W    = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic [NUM_VOICES*(WI_IN+WF_IN)-1:0] voices_in,
    input  logic [NUM_VOICES-1:0]               voice_en,
    input  logic [SHIFT_W-1:0]                  gain_shift,
    input  logic                                clr_clip,
    output logic                                out_valid,
    output logic [WI_OUT+WF_OUT-1:0]            mix_out,
    output logic                                clip,
    output logic                                clip_sticky
);

    localparam int WIN    = WI_IN + WF_IN;
    localparam int LEVELS = clog2(NUM_VOICES);
    localparam int PADDED = 1 << LEVELS;
    localparam int SUM_W  = WIN + LEVELS;
    localparam int WOUT   = WI_OUT + WF_OUT;
    localparam int AW     = WI_IN + LEVELS + WF_OUT;
    localparam int TREE_W = tree_offset(LEVELS, WIN, LEVELS + 1);

    logic [PADDED*WIN-1:0] w_masked;
    logic [PADDED*WIN-1:0] r_voices;
    logic [SHIFT_W-1:0]    r_shift [0:LEVELS];
    logic [LEVELS+1:0]     r_valid;

    // Disabled voices and the padding slots above NUM_VOICES enter the tree as zero.
    always_comb begin
        w_masked = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (voice_en[i]) begin
                w_masked[i*WIN +: WIN] = voices_in[i*WIN +: WIN];
            end
        end
    end

    // gain_shift travels alongside its frame so mid-stream changes never touch frames in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_voices <= '0;
            r_valid  <= '0;
            for (int k = 0; k <= LEVELS; k++) begin
                r_shift[k] <= '0;
            end
        end else begin
            r_voices   <= w_masked;
            r_valid    <= {r_valid[LEVELS:0], in_valid};
            r_shift[0] <= gain_shift;
            for (int k = 1; k <= LEVELS; k++) begin
                r_shift[k] <= r_shift[k-1];
            end
        end
    end

    wire [TREE_W-1:0] w_tree;

    assign w_tree[PADDED*WIN-1:0] = r_voices;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int IN_W    = WIN + k - 1;
        localparam int PAIRS   = 1 << (LEVELS - k);
        localparam int OFF_IN  = tree_offset(LEVELS, WIN, k - 1);
        localparam int OFF_OUT = tree_offset(LEVELS, WIN, k);

        mix_add_stage #(
            .IN_W  (IN_W),
            .PAIRS (PAIRS)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .i_operands (w_tree[OFF_IN +: 2*PAIRS*IN_W]),
            .o_sums     (w_tree[OFF_OUT +: PAIRS*(IN_W+1)])
        );
    end

    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_shifted;
    logic signed [AW-1:0]    w_aligned;
    logic [WOUT-1:0]         w_sat;
    logic                    w_overflow;

    assign w_sum     = $signed(w_tree[TREE_W-1 -: SUM_W]);
    assign w_shifted = w_sum >>> r_shift[LEVELS];

    if (WF_OUT == WF_IN) begin : g_align_same
        assign w_aligned = w_shifted;
    end else if (WF_OUT > WF_IN) begin : g_align_pad
        assign w_aligned = {w_shifted, {(WF_OUT-WF_IN){1'b0}}};
    end else begin : g_align_trunc
        assign w_aligned = w_shifted[SUM_W-1 -: AW];
    end

    // Overflow exactly when the bits above the output sign bit disagree with it.
    if (AW > WOUT) begin : g_sat
        localparam int TOP_W = AW - WOUT + 1;
        logic [TOP_W-1:0] w_top;
        assign w_top      = w_aligned[AW-1 -: TOP_W];
        assign w_overflow = ~((&w_top) | ~(|w_top));
        assign w_sat      = !w_overflow  ? w_aligned[WOUT-1:0] :
                            w_aligned[AW-1] ? {1'b1, {(WOUT-1){1'b0}}} :
                                              {1'b0, {(WOUT-1){1'b1}}};
    end else if (AW == WOUT) begin : g_fit
        assign w_overflow = 1'b0;
        assign w_sat      = w_aligned;
    end else begin : g_extend
        assign w_overflow = 1'b0;
        assign w_sat      = {{(WOUT-AW){w_aligned[AW-1]}}, w_aligned};
    end

    logic [WOUT-1:0] r_mix;
    logic            r_clip;
    logic            r_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mix  <= '0;
            r_clip <= 1'b0;
        end else begin
            r_mix  <= w_sat;
            r_clip <= w_overflow;
        end
    end

    // A clip arriving in the same cycle as clr_clip keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (r_valid[LEVELS+1] && r_clip) begin
            r_sticky <= 1'b1;
        end else if (clr_clip) begin
            r_sticky <= 1'b0;
        end
    end

    assign out_valid   = r_valid[LEVELS+1];
    assign mix_out     = r_mix;
    assign clip        = r_clip;
    assign clip_sticky = r_sticky;

endmodule

// File: tb/tb_voice_mix_pipe.sv
// Scoreboard bench: three mixer configurations (default, narrow output, five voices)
// driven with directed and random frames and compared against an arithmetic reference.
module tb_voice_mix_pipe;

    localparam int WV = 18;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            aValid, aClr, aOutValid, aClip, aSticky;
    logic [16*WV-1:0] aVoices;
    logic [15:0]     aEn;
    logic [2:0]      aShift;
    logic [23:0]     aMix;

    logic            bValid, bClr, bOutValid, bClip, bSticky;
    logic [16*WV-1:0] bVoices;
    logic [15:0]     bEn;
    logic [2:0]      bShift;
    logic [21:0]     bMix;

    logic            cValid, cClr, cOutValid, cClip, cSticky;
    logic [5*WV-1:0] cVoices;
    logic [4:0]      cEn;
    logic [2:0]      cShift;
    logic [23:0]     cMix;

    voice_mix_pipe dutA (
        .clk(clk), .rst(rst), .in_valid(aValid), .voices_in(aVoices), .voice_en(aEn),
        .gain_shift(aShift), .clr_clip(aClr), .out_valid(aOutValid), .mix_out(aMix),
        .clip(aClip), .clip_sticky(aSticky)
    );

    voice_mix_pipe #(.WI_OUT(4)) dutB (
        .clk(clk), .rst(rst), .in_valid(bValid), .voices_in(bVoices), .voice_en(bEn),
        .gain_shift(bShift), .clr_clip(bClr), .out_valid(bOutValid), .mix_out(bMix),
        .clip(bClip), .clip_sticky(bSticky)
    );

    voice_mix_pipe #(.NUM_VOICES(5)) dutC (
        .clk(clk), .rst(rst), .in_valid(cValid), .voices_in(cVoices), .voice_en(cEn),
        .gain_shift(cShift), .clr_clip(cClr), .out_valid(cOutValid), .mix_out(cMix),
        .clip(cClip), .clip_sticky(cSticky)
    );

    typedef struct {
        longint mix;
        bit     clip;
        longint due;
    } exp_t;

    exp_t   expA[$];
    exp_t   expB[$];
    exp_t   expC[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    task automatic checkOutput(input string name, input longint actual, input longint required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    // Reference: exact sum of enabled voices, floor-divided by 2**sh, rescaled from
    // 16 to 18 fraction bits, clamped to the signed output range.
    function automatic exp_t refMix(input int v[16], input int nv, input logic [15:0] en,
                                    input int sh, input int wiOut, input int lat);
        exp_t   e;
        longint sum, div, q, lim;
        sum = 0;
        for (int i = 0; i < nv; i++) begin
            if (en[i]) sum += v[i];
        end
        div = longint'(1) << sh;
        q = sum / div;
        if (sum < 0 && q * div != sum) q = q - 1;
        q = q * 4;
        lim = longint'(1) << (wiOut + 17);
        e.clip = 1'b0;
        if (q > lim - 1) begin
            q = lim - 1;
            e.clip = 1'b1;
        end else if (q < -lim) begin
            q = -lim;
            e.clip = 1'b1;
        end
        e.mix = q & ((lim << 1) - 1);
        e.due = cyc + lat;
        return e;
    endfunction

    function automatic void fillVoices(output int v[16], input int value);
        for (int i = 0; i < 16; i++) v[i] = value;
    endfunction

    function automatic void randVoices(output int v[16]);
        logic signed [WV-1:0] s;
        for (int i = 0; i < 16; i++) begin
            s = WV'($urandom);
            v[i] = s;
        end
    endfunction

    task automatic applyStimulus(input int which, input int v[16], input logic [15:0] en, input int sh);
        logic [16*WV-1:0] bus;
        for (int i = 0; i < 16; i++) bus[i*WV +: WV] = v[i][WV-1:0];
        case (which)
            0: begin
                aVoices = bus; aEn = en; aShift = 3'(sh); aValid = 1'b1;
                expA.push_back(refMix(v, 16, en, sh, 6, 6));
            end
            1: begin
                bVoices = bus; bEn = en; bShift = 3'(sh); bValid = 1'b1;
                expB.push_back(refMix(v, 16, en, sh, 4, 6));
            end
            default: begin
                cVoices = bus[5*WV-1:0]; cEn = en[4:0]; cShift = 3'(sh); cValid = 1'b1;
                expC.push_back(refMix(v, 5, en, sh, 6, 5));
            end
        endcase
        @(posedge clk); #1;
        aValid = 1'b0; bValid = 1'b0; cValid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expA.size() + expB.size() + expC.size()) != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain", longint'(expA.size() + expB.size() + expC.size()), 0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (aOutValid) begin
                if (expA.size() == 0) checkOutput("A unexpected out_valid", 1, 0);
                else begin
                    e = expA.pop_front();
                    checkOutput("A latency", cyc, e.due);
                    checkOutput("A mix", longint'(aMix), e.mix);
                    checkOutput("A clip", longint'(aClip), longint'(e.clip));
                end
            end
            if (bOutValid) begin
                if (expB.size() == 0) checkOutput("B unexpected out_valid", 1, 0);
                else begin
                    e = expB.pop_front();
                    checkOutput("B latency", cyc, e.due);
                    checkOutput("B mix", longint'(bMix), e.mix);
                    checkOutput("B clip", longint'(bClip), longint'(e.clip));
                end
            end
            if (cOutValid) begin
                if (expC.size() == 0) checkOutput("C unexpected out_valid", 1, 0);
                else begin
                    e = expC.pop_front();
                    checkOutput("C latency", cyc, e.due);
                    checkOutput("C mix", longint'(cMix), e.mix);
                    checkOutput("C clip", longint'(cClip), longint'(e.clip));
                end
            end
            cyc++;
        end
    endtask

    initial begin
        int          v[16];
        int          seen;
        logic [15:0] en;

        rst = 1'b1;
        aValid = 1'b0; aClr = 1'b0; aVoices = '0; aEn = '0; aShift = '0;
        bValid = 1'b0; bClr = 1'b0; bVoices = '0; bEn = '0; bShift = '0;
        cValid = 1'b0; cClr = 1'b0; cVoices = '0; cEn = '0; cShift = '0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid", longint'(aOutValid), 0);
        checkOutput("reset mix_out", longint'(aMix), 0);
        checkOutput("reset clip", longint'(aClip), 0);
        checkOutput("reset clip_sticky", longint'(aSticky), 0);
        checkOutput("reset B clip_sticky", longint'(bSticky), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed frames, default configuration");
        fillVoices(v, 65536);
        applyStimulus(0, v, 16'hFFFF, 0);
        waitDrain();
        fillVoices(v, -131072);
        applyStimulus(0, v, 16'hFFFF, 0);
        waitDrain();
        randVoices(v);
        v[3] = 32768;
        applyStimulus(0, v, 16'h0008, 0);
        fillVoices(v, 65536);
        applyStimulus(0, v, 16'hFFFF, 4);
        waitDrain();

        $display("[TB] random back-to-back frames, default configuration");
        for (int n = 0; n < 30; n++) begin
            randVoices(v);
            en = 16'($urandom);
            applyStimulus(0, v, en, $urandom_range(7, 0));
        end
        waitDrain();

        $display("[TB] saturation and sticky clip, narrow output");
        fillVoices(v, 65536);
        applyStimulus(1, v, 16'hFFFF, 0);
        waitDrain();
        checkOutput("sticky after clip", longint'(bSticky), 1);
        bClr = 1'b1;
        @(posedge clk); #1;
        bClr = 1'b0;
        checkOutput("sticky after clr_clip", longint'(bSticky), 0);
        bClr = 1'b1;
        fillVoices(v, -131072);
        applyStimulus(1, v, 16'hFFFF, 0);
        waitDrain();
        checkOutput("sticky set beats clear", longint'(bSticky), 1);
        @(posedge clk); #1;
        checkOutput("sticky cleared after set", longint'(bSticky), 0);
        bClr = 1'b0;
        for (int n = 0; n < 20; n++) begin
            randVoices(v);
            applyStimulus(1, v, 16'($urandom), $urandom_range(3, 0));
        end
        fillVoices(v, 65536);
        applyStimulus(1, v, 16'hFFFF, 0);
        waitDrain();
        checkOutput("sticky before reset", longint'(bSticky), 1);

        $display("[TB] five voices, 20 consecutive random frames");
        for (int n = 0; n < 20; n++) begin
            randVoices(v);
            applyStimulus(2, v, 16'($urandom), $urandom_range(7, 0));
        end
        waitDrain();

        $display("[TB] reset with frames in flight");
        for (int n = 0; n < 8; n++) begin
            fillVoices(v, 65536);
            v[n] = 98304;
            applyStimulus(0, v, 16'hFFFF, 0);
        end
        checkOutput("out_valid before reset", longint'(aOutValid), 1);
        rst = 1'b1;
        #1;
        expA.delete();
        checkOutput("mid reset out_valid", longint'(aOutValid), 0);
        checkOutput("mid reset mix_out", longint'(aMix), 0);
        checkOutput("mid reset clip", longint'(aClip), 0);
        checkOutput("mid reset B clip_sticky", longint'(bSticky), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (aOutValid || bOutValid || cOutValid) seen++;
        end
        checkOutput("no output after reset", longint'(seen), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
